// File: rtl/register_load_arbiter.sv
// Round-robin arbiter owning the shared enable register's en/d port.
// Loads one requester's value, verifies it through q, retries, then acks or errs.
module register_load_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 7,
  parameter int MAX_RETRY = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       err,
  output logic                     reg_en,
  output logic [WIDTH-1:0]         reg_d,
  input  logic [WIDTH-1:0]         reg_q,
  output logic                     busy,
  output logic [2:0]               grant_idx,
  output logic [7:0]               load_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    RESP
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       last_grant;
  logic [2:0]       retry;
  logic [2:0]       win_idx;
  logic             win_found;
  logic             ok_q;
  logic             match;
  logic             retry_done;
  logic [3:0]       cand;
  logic [7:0]       req_ext;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] data_arr [8];

  always_comb begin
    req_ext = '0;
    req_ext[NUM_REQ-1:0] = req;
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < NUM_REQ; i++)
      data_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  // search starts one past the last grantee, wrapping at NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_grant;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!win_found && req_ext[cand[2:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[2:0];
      end
    end
  end

  assign match      = (reg_q == hold);
  assign retry_done = (retry == 3'(MAX_RETRY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (win_found) state_nx = LOAD;
      LOAD:  state_nx = CHECK;
      CHECK: state_nx = (match || retry_done) ? RESP : LOAD;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_idx  <= '0;
      last_grant <= 3'(NUM_REQ - 1);
      hold       <= '0;
      retry      <= '0;
      ok_q       <= 1'b0;
      load_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_found) begin
            grant_idx <= win_idx;
            hold      <= data_arr[win_idx];
            retry     <= '0;
            ok_q      <= 1'b0;
          end
        end
        CHECK: begin
          if (match)            ok_q  <= 1'b1;
          else if (!retry_done) retry <= retry + 3'd1;
        end
        RESP: begin
          last_grant <= grant_idx;
          if (ok_q && load_count != 8'hFF)
            load_count <= load_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign reg_en = (state == LOAD);
  assign reg_d  = hold;
  assign busy   = (state != IDLE);

  always_comb begin
    ack = '0;
    err = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ack[i] = (state == RESP) && ok_q  && (grant_idx == 3'(i));
      err[i] = (state == RESP) && !ok_q && (grant_idx == 3'(i));
    end
  end

endmodule

// File: tb/tb_register_load_arbiter.sv
// Scoreboard bench for register_load_arbiter with a behavioural register
// whose readback can be corrupted for a chosen number of loads.
module tb_register_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [27:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic        reg_en;
  logic [6:0]  reg_d;
  logic [6:0]  reg_q;
  logic        busy;
  logic [2:0]  grant_idx;
  logic [7:0]  load_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [6:0] data;
    bit         ok;
  } exp_t;

  exp_t sb[$];

  logic [6:0] reg_model = '0;
  int en_total  = 0;
  int en_base   = 0;
  int bad_limit = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_en) begin
      reg_model <= reg_d;
      en_total  <= en_total + 1;
    end
  end

  assign reg_q = ((en_total - en_base) >= 1 &&
                  (en_total - en_base) <= bad_limit)
                 ? (reg_model ^ 7'h01) : reg_model;

  register_load_arbiter #(
    .NUM_REQ(4), .WIDTH(7), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack), .err(err), .reg_en(reg_en), .reg_d(reg_d),
    .reg_q(reg_q), .busy(busy), .grant_idx(grant_idx),
    .load_count(load_count)
  );

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack !== 4'b0 || err !== 4'b0) begin
      failures++;
      $display("FAIL reset_resp ack=%b err=%b want 0000/0000", ack, err);
    end
    checks++;
    if (reg_en !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl reg_en=%b busy=%b want 0/0", reg_en, busy);
    end
    checks++;
    if (reg_d !== 7'h00 || grant_idx !== 3'd0) begin
      failures++;
      $display("FAIL reset_data reg_d=%h grant=%0d want 00/0",
               reg_d, grant_idx);
    end
    checks++;
    if (load_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got %0d want 0", load_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int n_en;
    int k_ack;
    logic [3:0] oh;
    exp_t e;
    n_en = 0;
    k_ack = -1;
    req_data = '0;
    req_data[6:0] = 7'h55;
    req = 4'b0001;
    sb.push_back('{0, 7'h55, 1'b1});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (reg_en) begin
        n_en++;
        checks++;
        if (reg_d !== 7'h55 || k != 1) begin
          failures++;
          $display("FAIL single_load cyc=%0d reg_d=%h want cyc 1 55", k, reg_d);
        end
      end
      checks++;
      if (busy !== (k <= 3)) begin
        failures++;
        $display("FAIL single_busy cyc=%0d got %b want %b", k, busy, k <= 3);
      end
      if ((ack | err) != 4'b0) begin
        k_ack = k;
        req = '0;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL single_resp unexpected ack=%b err=%b", ack, err);
        end else begin
          e = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (ack !== oh || err !== 4'b0 || grant_idx !== 3'(e.idx)) begin
            failures++;
            $display("FAIL single_resp ack=%b err=%b want %b/0000",
                     ack, err, oh);
          end
        end
      end
    end
    checks++;
    if (k_ack != 3 || n_en != 1) begin
      failures++;
      $display("FAIL single_timing ack_cyc=%0d loads=%0d want 3/1", k_ack, n_en);
    end
    checks++;
    if (load_count !== 8'd1) begin
      failures++;
      $display("FAIL single_count got %0d want 1", load_count);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL single_missing pending=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_round_robin();
    int n_ack;
    logic [3:0] oh;
    exp_t e;
    pulse_reset();
    n_ack = 0;
    req_data = {7'h44, 7'h33, 7'h22, 7'h11};
    req = 4'b1111;
    sb.push_back('{0, 7'h11, 1'b1});
    sb.push_back('{1, 7'h22, 1'b1});
    sb.push_back('{2, 7'h33, 1'b1});
    sb.push_back('{3, 7'h44, 1'b1});
    sb.push_back('{0, 7'h11, 1'b1});
    for (int k = 1; k <= 24 && n_ack < 5; k++) begin
      @(negedge clk);
      if (reg_en && sb.size() != 0) begin
        checks++;
        if (reg_d !== sb[0].data) begin
          failures++;
          $display("FAIL rr_load cyc=%0d reg_d=%h want %h", k, reg_d, sb[0].data);
        end
      end
      if ((ack | err) != 4'b0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rr_resp unexpected ack=%b err=%b", ack, err);
        end else begin
          e = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (ack !== oh || err !== 4'b0 || k != 3 + 4 * n_ack) begin
            failures++;
            $display("FAIL rr_resp cyc=%0d ack=%b err=%b want cyc %0d ack %b",
                     k, ack, err, 3 + 4 * n_ack, oh);
          end
        end
        n_ack++;
        if (n_ack == 5) req = '0;
      end
    end
    req = '0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rr_missing pending=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_retry();
    int n_en;
    int k_ack;
    exp_t e;
    @(negedge clk);
    n_en = 0;
    k_ack = -1;
    en_base = en_total;
    bad_limit = 2;
    req_data[6:0] = 7'h3C;
    req = 4'b0001;
    sb.push_back('{0, 7'h3C, 1'b1});
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (reg_en) n_en++;
      if ((ack | err) != 4'b0) begin
        k_ack = k;
        req = '0;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL retry_resp unexpected ack=%b err=%b", ack, err);
        end else begin
          e = sb.pop_front();
          if (ack !== 4'b0001 || err !== 4'b0) begin
            failures++;
            $display("FAIL retry_resp ack=%b err=%b want 0001/0000", ack, err);
          end
        end
      end
    end
    checks++;
    if (k_ack != 7 || n_en != 3) begin
      failures++;
      $display("FAIL retry_timing ack_cyc=%0d loads=%0d want 7/3", k_ack, n_en);
    end
    bad_limit = 0;
    sb.delete();
  endtask

  task automatic test_fail();
    int n_en;
    int k_err;
    logic [7:0] lc0;
    exp_t e;
    @(negedge clk);
    n_en = 0;
    k_err = -1;
    lc0 = load_count;
    en_base = en_total;
    bad_limit = 1000;
    req_data[6:0] = 7'h66;
    req = 4'b0001;
    sb.push_back('{0, 7'h66, 1'b0});
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (reg_en) n_en++;
      if ((ack | err) != 4'b0) begin
        k_err = k;
        req = '0;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL fail_resp unexpected ack=%b err=%b", ack, err);
        end else begin
          e = sb.pop_front();
          if (err !== 4'b0001 || ack !== 4'b0) begin
            failures++;
            $display("FAIL fail_resp ack=%b err=%b want 0000/0001", ack, err);
          end
        end
      end
    end
    checks++;
    if (k_err != 9 || n_en != 4) begin
      failures++;
      $display("FAIL fail_timing err_cyc=%0d loads=%0d want 9/4", k_err, n_en);
    end
    checks++;
    if (load_count !== lc0) begin
      failures++;
      $display("FAIL fail_count got %0d want %0d", load_count, lc0);
    end
    bad_limit = 0;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int n_ack;
    logic [3:0] oh;
    exp_t e;
    @(negedge clk);
    n_ack = 0;
    req_data = {7'h00, 7'h00, 7'h2B, 7'h1A};
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (reg_en !== 1'b1 || grant_idx !== 3'd1) begin
      failures++;
      $display("FAIL rstmid_load reg_en=%b grant=%0d want 1/1", reg_en, grant_idx);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (reg_en !== 1'b0 || busy !== 1'b0 || (ack | err) !== 4'b0) begin
      failures++;
      $display("FAIL rstmid_abort reg_en=%b busy=%b ack=%b err=%b want 0",
               reg_en, busy, ack, err);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{0, 7'h1A, 1'b1});
    sb.push_back('{1, 7'h2B, 1'b1});
    for (int k = 1; k <= 12 && n_ack < 2; k++) begin
      @(negedge clk);
      if ((ack | err) != 4'b0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rstmid_resp unexpected ack=%b err=%b", ack, err);
        end else begin
          e = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (ack !== oh || err !== 4'b0 || k != 3 + 4 * n_ack) begin
            failures++;
            $display("FAIL rstmid_resp cyc=%0d ack=%b want cyc %0d ack %b",
                     k, ack, 3 + 4 * n_ack, oh);
          end
        end
        n_ack++;
        if (n_ack == 2) req = '0;
      end
    end
    req = '0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rstmid_missing pending=%0d want 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_saturate();
    int n_ack;
    int n_bad;
    logic [3:0] oh;
    exp_t e;
    pulse_reset();
    n_ack = 0;
    n_bad = 0;
    req_data = '0;
    req_data[6:0] = 7'h2A;
    req = 4'b0001;
    for (int k = 1; k <= 1500 && n_ack < 260; k++) begin
      @(negedge clk);
      if ((ack | err) != 4'b0) begin
        if (ack !== 4'b0001 || err !== 4'b0) n_bad++;
        n_ack++;
        if (n_ack == 260) req = '0;
      end
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (n_ack != 260 || n_bad != 0) begin
      failures++;
      $display("FAIL sat_acks got %0d bad=%0d want 260/0", n_ack, n_bad);
    end
    checks++;
    if (load_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_count got %0d want 255", load_count);
    end
    req_data[20:14] = 7'h5A;
    req = 4'b0100;
    sb.push_back('{2, 7'h5A, 1'b1});
    n_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (reg_en) begin
        checks++;
        if (reg_d !== 7'h5A) begin
          failures++;
          $display("FAIL drop_load reg_d=%h want 5a", reg_d);
        end
      end
      if (k == 1) begin
        req = '0;
        req_data[20:14] = 7'h0F;
      end
      if ((ack | err) != 4'b0) begin
        n_ack++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL drop_resp unexpected ack=%b err=%b", ack, err);
        end else begin
          e = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (ack !== oh || err !== 4'b0 || k != 3) begin
            failures++;
            $display("FAIL drop_resp cyc=%0d ack=%b want cyc 3 ack %b", k, ack, oh);
          end
        end
      end
    end
    checks++;
    if (n_ack != 1 || load_count !== 8'd255) begin
      failures++;
      $display("FAIL drop_count acks=%0d count=%0d want 1/255", n_ack, load_count);
    end
    sb.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_fail();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
